// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: detects RAW data hazards between D and E/M, tracks the
// multiply/divide unit's busy window, and freezes F/D while inserting bubbles into E.
module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_rs_tuse,
  input  logic [1:0]  D_rt_tuse,
  input  logic        D_is_md,
  input  logic [4:0]  E_A3,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  output logic        F_enable,
  output logic        D_enable,
  output logic        E_clear,
  output logic        md_busy,
  output logic [31:0] stall_count
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] stall_count_q, stall_count_d;

  logic data_stall, md_stall, stall;

  // A producer hazards a consumer only when its result arrives later than the consumer
  // needs it; tuse=3 can never be exceeded, so unused operands fall out naturally.
  function automatic logic hit(input logic [4:0] src, input logic [1:0] tuse,
                               input logic [4:0] a3,  input logic [1:0] tnew);
    return (src != 5'd0) && (src == a3) && (tnew > tuse);
  endfunction

  always_comb begin
    data_stall = hit(D_rs, D_rs_tuse, E_A3, E_tnew) || hit(D_rs, D_rs_tuse, M_A3, M_tnew) ||
                 hit(D_rt, D_rt_tuse, E_A3, E_tnew) || hit(D_rt, D_rt_tuse, M_A3, M_tnew);
    md_busy    = E_md_start || (state_q == BUSY);
    md_stall   = D_is_md && md_busy;
    stall      = data_stall || md_stall;
    F_enable   = !stall;
    D_enable   = !stall;
    E_clear    = stall;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (E_md_start) begin
          cnt_d = E_md_is_div ? DIV_LD : MULT_LD;
          if (cnt_d != 4'd0) state_d = BUSY;
        end
      end
      BUSY: begin
        // Starts seen here belong to the running window and are dropped.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 32'hFFFF_FFFF)) stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      stall_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
